axis_postwrite_fifo: RTL and testbench

Output-side counterpart of the AXIS preload path. It accepts full-width 5-bit-per-channel result vectors (5*MAC_NUM bits) from the MAC array into a small FIFO. It serializes each vector into 32-bit AXI4-Stream beats, six 5-bit values per beat, and drives them out to the DMA write channel. `m_axis_tlast` marks frame boundaries.

---
 rtl/axis_postwrite_fifo_if.sv | 23 ++
 rtl/axis_postwrite_fifo.sv | 170 +++++++++++++++++
 tb/tb_axis_postwrite_fifo.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_postwrite_fifo_if.sv
// AXI4-Stream beat channel between the post-write serializer and the DMA write port.
interface axis_postwrite_fifo_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_postwrite_fifo.sv
// axis_postwrite_fifo: buffers full-width MAC result vectors in a small FIFO and
// serializes each one into 32-bit AXI4-Stream beats of six 5-bit channels.
// tlast marks the final beat of the final vector of every frame.
module axis_postwrite_fifo #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int MAC_NUM              = 256,
    parameter int OUT_FIFO_DEPTH       = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [5*MAC_NUM-1:0]            ofmaps_in,
    input  logic                            ofmaps_valid,
    output logic                            ofmaps_ready,
    input  logic [11:0]                     output_channel_size,
    input  logic [15:0]                     frame_words,
    axis_postwrite_fifo_if.master           m_axis,
    output logic [$clog2(OUT_FIFO_DEPTH):0] fifo_cnt,
    output logic                            busy
);
    localparam int VEC_W = 5 * MAC_NUM;
    localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [VEC_W-1:0] mem_q [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    state_t           state_q;
    state_t           state_d;
    logic [VEC_W-1:0] cur_q;
    logic [12:0]      off_q;
    logic [12:0]      off_d;
    logic [15:0]      wcnt_q;
    logic [15:0]      wcnt_d;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             last_beat;
    logic             wcnt_last;
    logic [15:0]      fw_eff;
    logic [29:0]      win;
    logic [29:0]      beat_data;
    logic [13:0]      ch;

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CNT_W'(OUT_FIFO_DEPTH));
    // A full FIFO still accepts a write in the cycle the serializer pops,
    // so ready depends combinationally on the sink's tready.
    assign ofmaps_ready = !full || pop;
    assign push         = ofmaps_valid && ofmaps_ready;

    assign fw_eff    = (frame_words == 16'd0) ? 16'd1 : frame_words;
    assign wcnt_last = (wcnt_q == (fw_eff - 16'd1));
    assign last_beat = ({1'b0, off_q} + 14'd6) >= {2'b00, output_channel_size};

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ofmaps_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Occupancy next-state: simultaneous push and pop cancel out
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Serializer vector register: loaded on every pop, data only
    always_ff @(posedge clk) begin
        if (pop) begin
            cur_q <= mem_q[rd_ptr_q];
        end
    end

    // Serializer control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Serializer next-state: reload straight from the FIFO after a last beat so
    // consecutive vectors stream without a bubble
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        wcnt_d  = wcnt_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    off_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (m_axis.tready) begin
                    if (!last_beat) begin
                        off_d = off_q + 13'd6;
                    end else begin
                        wcnt_d = wcnt_last ? 16'd0 : (wcnt_q + 16'd1);
                        off_d  = '0;
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Beat extraction: six channels starting at off, channels past the valid
    // count (or past the array width) forced to zero
    always_comb begin
        win       = 30'(cur_q >> ({off_q, 2'b00} + {2'b00, off_q}));
        beat_data = '0;
        ch        = '0;
        for (int k = 0; k < 6; k++) begin
            ch = {1'b0, off_q} + 14'(k);
            if ((ch < {2'b00, output_channel_size}) && (ch < 14'(MAC_NUM))) begin
                beat_data[5*k +: 5] = win[5*k +: 5];
            end
        end
    end

    assign m_axis.tvalid = (state_q == S_SEND);
    assign m_axis.tlast  = (state_q == S_SEND) && last_beat && wcnt_last;
    assign m_axis.tdata  = (state_q == S_SEND)
                         ? {{(C_M_AXIS_TDATA_WIDTH-30){1'b0}}, beat_data}
                         : '0;

    assign fifo_cnt = cnt_q;
    assign busy     = !empty || (state_q == S_SEND);
endmodule

// File: tb/tb_axis_postwrite_fifo.sv
// Directed testbench for axis_postwrite_fifo: one task per scenario, each with
// inline comparisons against hand-computed expectations.
module tb_axis_postwrite_fifo;
    localparam int MAC   = 256;
    localparam int DEPTH = 2;
    // Six copies of the value 1 packed at 5-bit spacing; v*REP6 is a beat of six v's.
    localparam logic [31:0] REP6 = 32'h02108421;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [5*MAC-1:0]       ofmaps_in;
    logic                   ofmaps_valid;
    logic                   ofmaps_ready;
    logic [11:0]            ocs;
    logic [15:0]            fw;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stall_viol = 0;

    logic [31:0] bq_data [$];
    logic        bq_last [$];
    int          bq_cyc  [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    axis_postwrite_fifo_if #(.DATA_W(32)) axis ();

    axis_postwrite_fifo #(
        .C_M_AXIS_TDATA_WIDTH(32),
        .MAC_NUM(MAC),
        .OUT_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ofmaps_in(ofmaps_in),
        .ofmaps_valid(ofmaps_valid),
        .ofmaps_ready(ofmaps_ready),
        .output_channel_size(ocs),
        .frame_words(fw),
        .m_axis(axis),
        .fifo_cnt(fifo_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat recorder and stall-stability tracker, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (axis.tvalid && axis.tready) begin
                bq_data.push_back(axis.tdata);
                bq_last.push_back(axis.tlast);
                bq_cyc.push_back(cyc);
            end
            if (prev_stall && ((axis.tdata !== prev_data) || (axis.tlast !== prev_last)))
                stall_viol <= stall_viol + 1;
            prev_stall <= axis.tvalid && !axis.tready;
            prev_data  <= axis.tdata;
            prev_last  <= axis.tlast;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    function automatic logic [5*MAC-1:0] mk_vec(input logic [4:0] v);
        return {MAC{v}};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ofmaps_valid = 1'b0;
        ofmaps_in = '0;
        axis.tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push_vec(input logic [5*MAC-1:0] v, output bit ok);
        ok = 1'b0;
        ofmaps_in = v;
        ofmaps_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            #2;
            if (ofmaps_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        ofmaps_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bq_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ofmaps_valid = 1'b0;
        axis.tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", axis.tvalid); end
        n_checks++; if (axis.tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h expected 00000000", axis.tdata); end
        n_checks++; if (axis.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", axis.tlast); end
        n_checks++; if (fifo_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_fifo_cnt: got %0d expected 0", fifo_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (ofmaps_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ofmaps_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_vector();
        logic [5*MAC-1:0] v;
        int base;
        do_reset();
        ocs = 12'd12;
        fw = 16'd1;
        axis.tready = 1'b1;
        for (int c = 0; c < MAC; c++) v[5*c +: 5] = 5'(c % 32);
        base = bq_data.size();
        ofmaps_in = v;
        ofmaps_valid = 1'b1;
        #2;
        n_checks++; if (ofmaps_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", ofmaps_ready); end
        @(posedge clk); #1;
        ofmaps_valid = 1'b0;
        n_checks++; if (fifo_cnt !== 2'd1) begin n_fail++; $display("FAIL single_cnt_after_push: got %0d expected 1", fifo_cnt); end
        n_checks++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL single_tvalid_early: got %b expected 0", axis.tvalid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        @(posedge clk); #1;
        n_checks++; if (axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid_b0: got %b expected 1", axis.tvalid); end
        n_checks++; if (fifo_cnt !== 2'd0) begin n_fail++; $display("FAIL single_cnt_after_pop: got %0d expected 0", fifo_cnt); end
        n_checks++; if (axis.tdata !== 32'h0A418820) begin n_fail++; $display("FAIL single_beat0: got %h expected 0a418820", axis.tdata); end
        n_checks++; if (axis.tlast !== 1'b0) begin n_fail++; $display("FAIL single_tlast_b0: got %b expected 0", axis.tlast); end
        @(posedge clk); #1;
        n_checks++; if (axis.tdata !== 32'h16A4A0E6) begin n_fail++; $display("FAIL single_beat1: got %h expected 16a4a0e6", axis.tdata); end
        n_checks++; if (axis.tlast !== 1'b1) begin n_fail++; $display("FAIL single_tlast_b1: got %b expected 1", axis.tlast); end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        n_checks++; if (bq_data.size() - base !== 2) begin n_fail++; $display("FAIL single_beat_count: got %0d expected 2", bq_data.size() - base); end
    endtask

    task automatic test_full_width();
        int base;
        int nb;
        bit ok;
        do_reset();
        ocs = 12'd256;
        fw = 16'd1;
        axis.tready = 1'b1;
        base = bq_data.size();
        push_vec(mk_vec(5'h1F), ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_push: got timeout expected accept"); end
        wait_beats(base + 43, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_wait: got %0d beats expected 43", bq_data.size() - base); end
        repeat (3) begin @(posedge clk); #1; end
        nb = bq_data.size() - base;
        n_checks++; if (nb !== 43) begin n_fail++; $display("FAIL full_beat_count: got %0d expected 43", nb); end
        for (int i = 0; i < 42 && i < nb; i++) begin
            n_checks++;
            if (bq_data[base+i] !== 32'h3FFFFFFF || bq_last[base+i] !== 1'b0) begin
                n_fail++;
                $display("FAIL full_beat%0d: got %h/%b expected 3fffffff/0", i, bq_data[base+i], bq_last[base+i]);
            end
        end
        if (nb >= 43) begin
            n_checks++; if (bq_data[base+42] !== 32'h000FFFFF) begin n_fail++; $display("FAIL full_beat42: got %h expected 000fffff", bq_data[base+42]); end
            n_checks++; if (bq_last[base+42] !== 1'b1) begin n_fail++; $display("FAIL full_tlast42: got %b expected 1", bq_last[base+42]); end
            n_checks++; if (bq_cyc[base+42] - bq_cyc[base] !== 42) begin n_fail++; $display("FAIL full_throughput: got span %0d expected 42", bq_cyc[base+42] - bq_cyc[base]); end
        end
    endtask

    // Six 7-channel vectors, vector i filled with value i+1: two beats each,
    // beat 0 = (i+1)*REP6, beat 1 = channel 6 only = i+1.
    task automatic check_six_by_seven(input int base, input string tag, input bit chk_gap);
        int nb;
        logic [31:0] exp_d;
        logic        exp_l;
        nb = bq_data.size() - base;
        n_checks++; if (nb !== 12) begin n_fail++; $display("FAIL %s_beat_count: got %0d expected 12", tag, nb); end
        for (int j = 0; j < 12 && j < nb; j++) begin
            exp_d = (j % 2 == 0) ? REP6 * 32'(j/2 + 1) : 32'(j/2 + 1);
            exp_l = (j == 5) || (j == 11);
            n_checks++;
            if (bq_data[base+j] !== exp_d || bq_last[base+j] !== exp_l) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got %h/%b expected %h/%b", tag, j, bq_data[base+j], bq_last[base+j], exp_d, exp_l);
            end
        end
        if (chk_gap && nb >= 12) begin
            n_checks++; if (bq_cyc[base+11] - bq_cyc[base] !== 11) begin n_fail++; $display("FAIL %s_gap: got span %0d expected 11", tag, bq_cyc[base+11] - bq_cyc[base]); end
        end
    endtask

    task automatic test_frame_marking();
        int base;
        int bad;
        bit wok;
        do_reset();
        ocs = 12'd7;
        fw = 16'd3;
        axis.tready = 1'b1;
        base = bq_data.size();
        bad = 0;
        wok = 1'b0;
        fork
            begin
                bit pok;
                for (int i = 0; i < 6; i++) begin
                    push_vec(mk_vec(5'(i + 1)), pok);
                    if (!pok) bad++;
                end
            end
            begin
                wait_beats(base + 12, 300, wok);
            end
        join
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL frame_push: got %0d timeouts expected 0", bad); end
        n_checks++; if (!wok) begin n_fail++; $display("FAIL frame_wait: got %0d beats expected 12", bq_data.size() - base); end
        check_six_by_seven(base, "frame", 1'b1);
    endtask

    task automatic test_backpressure();
        int base;
        int bad;
        int viol0;
        do_reset();
        ocs = 12'd7;
        fw = 16'd3;
        base = bq_data.size();
        viol0 = stall_viol;
        bad = 0;
        fork
            begin
                bit pok;
                for (int i = 0; i < 6; i++) begin
                    push_vec(mk_vec(5'(i + 1)), pok);
                    if (!pok) bad++;
                end
            end
            begin
                for (int j = 0; j < 400; j++) begin
                    if (bq_data.size() >= base + 12) break;
                    if ((j >= 4 && j < 9) || (j >= 14 && j < 19)) axis.tready = 1'b0;
                    else axis.tready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                axis.tready = 1'b1;
            end
        join
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_push: got %0d timeouts expected 0", bad); end
        n_checks++; if (stall_viol - viol0 !== 0) begin n_fail++; $display("FAIL bp_stability: got %0d changes during stall expected 0", stall_viol - viol0); end
        check_six_by_seven(base, "bp", 1'b0);
    endtask

    task automatic test_full_simultaneous();
        int base;
        int nb;
        bit ok1, ok2, ok3;
        do_reset();
        ocs = 12'd6;
        fw = 16'd1;
        axis.tready = 1'b0;
        base = bq_data.size();
        push_vec(mk_vec(5'd1), ok1);
        push_vec(mk_vec(5'd2), ok2);
        push_vec(mk_vec(5'd3), ok3);
        n_checks++; if (!(ok1 && ok2 && ok3)) begin n_fail++; $display("FAIL fullsim_push: got %b%b%b expected 111", ok1, ok2, ok3); end
        n_checks++; if (fifo_cnt !== 2'd2) begin n_fail++; $display("FAIL fullsim_cnt_full: got %0d expected 2", fifo_cnt); end
        n_checks++; if (axis.tdata !== REP6) begin n_fail++; $display("FAIL fullsim_hold_data: got %h expected %h", axis.tdata, REP6); end
        ofmaps_in = mk_vec(5'd4);
        ofmaps_valid = 1'b1;
        #2;
        n_checks++; if (ofmaps_ready !== 1'b0) begin n_fail++; $display("FAIL fullsim_ready_low: got %b expected 0", ofmaps_ready); end
        @(posedge clk); #1;
        n_checks++; if (fifo_cnt !== 2'd2) begin n_fail++; $display("FAIL fullsim_cnt_blocked: got %0d expected 2", fifo_cnt); end
        axis.tready = 1'b1;
        #2;
        n_checks++; if (ofmaps_ready !== 1'b1) begin n_fail++; $display("FAIL fullsim_ready_on_pop: got %b expected 1", ofmaps_ready); end
        @(posedge clk); #1;
        ofmaps_valid = 1'b0;
        n_checks++; if (fifo_cnt !== 2'd2) begin n_fail++; $display("FAIL fullsim_cnt_pushpop: got %0d expected 2", fifo_cnt); end
        n_checks++; if (axis.tdata !== REP6 * 32'd2) begin n_fail++; $display("FAIL fullsim_next_data: got %h expected %h", axis.tdata, REP6 * 32'd2); end
        wait_beats(base + 4, 50, ok1);
        repeat (3) begin @(posedge clk); #1; end
        nb = bq_data.size() - base;
        n_checks++; if (nb !== 4) begin n_fail++; $display("FAIL fullsim_beat_count: got %0d expected 4", nb); end
        for (int j = 0; j < 4 && j < nb; j++) begin
            n_checks++;
            if (bq_data[base+j] !== REP6 * 32'(j + 1) || bq_last[base+j] !== 1'b1) begin
                n_fail++;
                $display("FAIL fullsim_beat%0d: got %h/%b expected %h/1", j, bq_data[base+j], bq_last[base+j], REP6 * 32'(j + 1));
            end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fullsim_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int nb;
        bit ok1, ok2, ok3, hit;
        do_reset();
        ocs = 12'd256;
        fw = 16'd2;
        axis.tready = 1'b1;
        base = bq_data.size();
        push_vec(mk_vec(5'd1), ok1);
        push_vec(mk_vec(5'h1F), ok2);
        push_vec(mk_vec(5'd2), ok3);
        n_checks++; if (!(ok1 && ok2 && ok3)) begin n_fail++; $display("FAIL rmid_push: got %b%b%b expected 111", ok1, ok2, ok3); end
        wait_beats(base + 63, 200, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rmid_wait: got %0d beats expected 63", bq_data.size() - base); end
        n_checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== 32'h3FFFFFFF) begin n_fail++; $display("FAIL rmid_beat20: got %b/%h expected 1/3fffffff", axis.tvalid, axis.tdata); end
        n_checks++; if (fifo_cnt !== 2'd1) begin n_fail++; $display("FAIL rmid_cnt_before: got %0d expected 1", fifo_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_tvalid: got %b expected 0", axis.tvalid); end
        n_checks++; if (axis.tdata !== 32'h0) begin n_fail++; $display("FAIL rmid_tdata: got %h expected 00000000", axis.tdata); end
        n_checks++; if (axis.tlast !== 1'b0) begin n_fail++; $display("FAIL rmid_tlast: got %b expected 0", axis.tlast); end
        n_checks++; if (fifo_cnt !== 2'd0) begin n_fail++; $display("FAIL rmid_fifo_cnt: got %0d expected 0", fifo_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_checks++; if (ofmaps_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", ofmaps_ready); end
        ocs = 12'd6;
        fw = 16'd2;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = bq_data.size();
        push_vec(mk_vec(5'd9), ok1);
        push_vec(mk_vec(5'd10), ok2);
        wait_beats(base + 2, 50, hit);
        repeat (3) begin @(posedge clk); #1; end
        nb = bq_data.size() - base;
        n_checks++; if (nb !== 2) begin n_fail++; $display("FAIL rmid_after_count: got %0d expected 2", nb); end
        if (nb >= 2) begin
            n_checks++; if (bq_data[base] !== REP6 * 32'd9 || bq_last[base] !== 1'b0) begin n_fail++; $display("FAIL rmid_after_b0: got %h/%b expected %h/0", bq_data[base], bq_last[base], REP6 * 32'd9); end
            n_checks++; if (bq_data[base+1] !== REP6 * 32'd10 || bq_last[base+1] !== 1'b1) begin n_fail++; $display("FAIL rmid_after_b1: got %h/%b expected %h/1", bq_data[base+1], bq_last[base+1], REP6 * 32'd10); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ofmaps_valid = 1'b0;
        ofmaps_in = '0;
        ocs = 12'd12;
        fw = 16'd1;
        axis.tready = 1'b0;
        test_reset();
        test_single_vector();
        test_full_width();
        test_frame_marking();
        test_backpressure();
        test_full_simultaneous();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
